// File: rtl/seg_scan_ctrl.sv
// Round-robin scan controller for common-anode seven-segment digits on a shared active-low bus.
// New display contents are double-buffered and swapped in only at frame boundaries.
module seg_scan_ctrl #(
   parameter int NDIG  = 8,
   parameter int DIV   = 1000,
   parameter int BLANK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [5*NDIG-1:0] wr_data,
   input  logic [NDIG-1:0]   wr_dp,
   output logic [NDIG-1:0]   an,
   output logic [7:0]        seg,
   output logic              frame_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

   logic [CW-1:0]      cnt;
   logic [IW-1:0]      idx;
   logic               pend_full;
   logic [5*NDIG-1:0]  pend_data;
   logic [NDIG-1:0]    pend_dp;
   logic [5*NDIG-1:0]  act_data;
   logic [NDIG-1:0]    act_dp;

   logic               frame_end;
   logic               in_blank;
   logic [4:0]         cur_code;
   logic               cur_dp;
   logic [NDIG-1:0]    cur_onehot;

   // Active-low a..g pattern; codes 16-31 are blank.
   function automatic logic [6:0] glyph(input logic [4:0] code);
      logic [6:0] g;
      case (code)
         5'd0:    g = 7'b0000001;
         5'd1:    g = 7'b1001111;
         5'd2:    g = 7'b0010010;
         5'd3:    g = 7'b0000110;
         5'd4:    g = 7'b1001100;
         5'd5:    g = 7'b0100100;
         5'd6:    g = 7'b0100000;
         5'd7:    g = 7'b0001111;
         5'd8:    g = 7'b0000000;
         5'd9:    g = 7'b0000100;
         5'd10:   g = 7'b0001000;
         5'd11:   g = 7'b1100000;
         5'd12:   g = 7'b1110010;
         5'd13:   g = 7'b1000010;
         5'd14:   g = 7'b0110000;
         5'd15:   g = 7'b0111000;
         default: g = 7'b1111111;
      endcase
      return g;
   endfunction

   assign wr_ready = ~pend_full & ~rst;

   always_comb begin
      frame_end  = en & (idx == IDX_LAST) & (cnt == CNT_LAST);
      in_blank   = int'(cnt) < BLANK;
      cur_code   = '0;
      cur_dp     = 1'b0;
      cur_onehot = '0;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (IW'(i) == idx) begin
            cur_code      = act_data[5*i +: 5];
            cur_dp        = act_dp[i];
            cur_onehot[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         pend_full  <= 1'b0;
         pend_data  <= '0;
         pend_dp    <= '0;
         act_data   <= {NDIG{5'd16}};
         act_dp     <= '0;
         an         <= '1;
         seg        <= '1;
         frame_tick <= 1'b0;
      end else begin
         // Accept needs pend_full=0 and commit needs pend_full=1, so they never collide.
         if (wr_valid && wr_ready) begin
            pend_data <= wr_data;
            pend_dp   <= wr_dp;
            pend_full <= 1'b1;
         end else if (pend_full && (!en || frame_end)) begin
            act_data  <= pend_data;
            act_dp    <= pend_dp;
            pend_full <= 1'b0;
         end

         if (en) begin
            if (cnt == CNT_LAST) begin
               cnt <= '0;
               idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
            if (in_blank) begin
               an  <= '1;
               seg <= '1;
            end else begin
               an  <= ~cur_onehot;
               seg <= {glyph(cur_code), ~cur_dp};
            end
            frame_tick <= frame_end;
         end else begin
            cnt        <= '0;
            idx        <= '0;
            an         <= '1;
            seg        <= '1;
            frame_tick <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

   localparam int NDIG  = 4;
   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = NDIG * DIV;

   // Lit segments a..g (active-high) for hex glyphs 0-F.
   localparam logic [6:0] LIT [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b0001101, 7'b0111101, 7'b1001111, 7'b1000111
   };

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              wr_valid;
   logic              wr_ready;
   logic [5*NDIG-1:0] wr_data;
   logic [NDIG-1:0]   wr_dp;
   logic [NDIG-1:0]   an;
   logic [7:0]        seg;
   logic              frame_tick;

   int checks = 0;
   int errors = 0;

   // Reference model state: position within frame plus pending/active frame copies.
   int   m_pos;
   bit   m_pfull;
   int   m_pcode [NDIG];
   bit   m_pdp   [NDIG];
   int   m_acode [NDIG];
   bit   m_adp   [NDIG];
   logic [NDIG-1:0] exp_an;
   logic [7:0]      exp_seg;
   logic            exp_ft;
   logic            exp_ready;

   seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .wr_dp      (wr_dp),
      .an         (an),
      .seg        (seg),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [7:0] seg_of(input int code, input bit dp);
      logic [6:0] lit;
      lit = (code < 16) ? LIT[code] : 7'b0;
      return {~lit, ~dp};
   endfunction

   task automatic model_step(input bit r, input bit e, input bit v,
                             input logic [5*NDIG-1:0] d, input logic [NDIG-1:0] dp);
      int  digit, slot;
      bit  accept, fend;
      if (r) begin
         m_pos   = 0;
         m_pfull = 0;
         for (int i = 0; i < NDIG; i++) begin
            m_acode[i] = 16;
            m_adp[i]   = 0;
         end
         exp_an = '1; exp_seg = 8'hFF; exp_ft = 1'b0;
      end else begin
         accept = v && !m_pfull;
         fend   = e && (m_pos == FRAME - 1);
         if (e) begin
            digit = m_pos / DIV;
            slot  = m_pos % DIV;
            if (slot < BLANK) begin
               exp_an  = '1;
               exp_seg = 8'hFF;
            end else begin
               exp_an  = '1;
               exp_an[digit] = 1'b0;
               exp_seg = seg_of(m_acode[digit], m_adp[digit]);
            end
            exp_ft = fend;
            m_pos  = (m_pos + 1) % FRAME;
         end else begin
            m_pos  = 0;
            exp_an = '1; exp_seg = 8'hFF; exp_ft = 1'b0;
         end
         if (m_pfull && (!e || fend)) begin
            for (int i = 0; i < NDIG; i++) begin
               m_acode[i] = m_pcode[i];
               m_adp[i]   = m_pdp[i];
            end
            m_pfull = 0;
         end
         if (accept) begin
            for (int i = 0; i < NDIG; i++) begin
               m_pcode[i] = int'(d[5*i +: 5]);
               m_pdp[i]   = dp[i];
            end
            m_pfull = 1;
         end
      end
      exp_ready = !m_pfull && !r;
   endtask

   initial begin
      bit                pv;
      logic [5*NDIG-1:0] pd;
      logic [NDIG-1:0]   pdp;
      bit                acc;
      bit                en_r;
      pv = 0; pd = '0; pdp = '0; en_r = 1;
      rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_dp = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = (cyc < 3) || ($urandom_range(0, 499) == 0);
         if (cyc >= 200) begin
            if (en_r && $urandom_range(0, 149) == 0) en_r = 0;
            else if (!en_r && $urandom_range(0, 19) == 0) en_r = 1;
         end
         en = en_r;
         if (cyc == 10) begin
            pv = 1; pd = {5'd12, 5'd8, 5'd1, 5'd0}; pdp = 4'b0100;
         end else if (cyc > 10 && !pv && $urandom_range(0, 15) == 0) begin
            pv = 1;
            for (int i = 0; i < NDIG; i++) pd[5*i +: 5] = 5'($urandom_range(0, 31));
            pdp = NDIG'($urandom);
         end
         wr_valid = pv; wr_data = pd; wr_dp = pdp;
         acc = pv && !m_pfull && !rst;
         model_step(rst, en, pv, pd, pdp);
         @(posedge clk);
         #1;
         check("an", 32'(an), 32'(exp_an));
         check("seg", 32'(seg), 32'(exp_seg));
         check("frame_tick", 32'(frame_tick), 32'(exp_ft));
         check("wr_ready", 32'(wr_ready), 32'(exp_ready));
         if (acc) pv = 0;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
